// File: rtl/spi_ram_pkg.sv
// Shared constants and state encoding for the SPI serial-SRAM responder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package spi_ram_pkg;

  localparam logic [7:0] CMD_READ  = 8'h03;
  localparam logic [7:0] CMD_WRITE = 8'h02;

  // The wire protocol always carries a 24-bit address, whatever the array depth.
  localparam int ADDR_FIELD_BITS = 24;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CMD    = 3'd1,
    ST_ADDR   = 3'd2,
    ST_READ   = 3'd3,
    ST_WRITE  = 3'd4,
    ST_IGNORE = 3'd5
  } state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// 2-FF synchronizer for one asynchronous input, with rise/fall pulses.
// Latency: 2 clk to sync_out; the edge pulses follow the synchronized level.
// Backpressure: none; a free-running sampler.
// Ports: clk/reset, async_in (raw pin), sync_out (synchronized level),
//        rise/fall (one-cycle pulses on synchronized edges).
module spi_sync_edge #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic sync_out,
  output logic rise,
  output logic fall
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
      prev_q <= RESET_VAL;
    end else begin
      meta_q <= async_in;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign sync_out = sync_q;
  assign rise     = sync_q & ~prev_q;
  assign fall     = ~sync_q & prev_q;

endmodule

// File: rtl/spi_ram_responder.sv
// SPI mode-0 serial-SRAM responder (READ/WRITE sequential) backed by a byte array.
// Latency: 3 clk from an SCLK/CS pin edge to internal action; bd_rdata 1 clk after bd_addr.
// Backpressure: none; the SPI master paces all traffic, clk must be >= 4x SCLK.
// Ports: clk/reset; spi_clk, spi_cs_n, spi_mosi, spi_miso (SPI pins);
//        busy (CS held), cmd_err (bad opcode pulse); bd_* backdoor array port.
module spi_ram_responder #(
  parameter int         ADDR_BITS = 10,
  parameter logic [7:0] CMD_READ  = 8'h03,
  parameter logic [7:0] CMD_WRITE = 8'h02
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 spi_clk,
  input  logic                 spi_cs_n,
  input  logic                 spi_mosi,
  output logic                 spi_miso,
  output logic                 busy,
  output logic                 cmd_err,
  input  logic                 bd_we,
  input  logic [ADDR_BITS-1:0] bd_addr,
  input  logic [7:0]           bd_wdata,
  output logic [7:0]           bd_rdata
);

  import spi_ram_pkg::*;

  localparam int DEPTH = 2 ** ADDR_BITS;
  localparam logic [4:0] LAST_ADDR_BIT = 5'(ADDR_FIELD_BITS - 1);

  logic sclk_sync, sclk_rise, sclk_fall;
  logic cs_sync, cs_rise, cs_fall;
  logic mosi_meta, mosi_s;

  spi_sync_edge #(.RESET_VAL(1'b0)) u_sclk_sync (
    .clk(clk), .reset(reset), .async_in(spi_clk),
    .sync_out(sclk_sync), .rise(sclk_rise), .fall(sclk_fall)
  );

  // CS resets to its idle (deasserted) level so reset release never fakes a select.
  spi_sync_edge #(.RESET_VAL(1'b1)) u_cs_sync (
    .clk(clk), .reset(reset), .async_in(spi_cs_n),
    .sync_out(cs_sync), .rise(cs_rise), .fall(cs_fall)
  );

  // Same depth as the SCLK path, so mosi_s is aligned with sclk_rise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mosi_meta <= 1'b0;
      mosi_s    <= 1'b0;
    end else begin
      mosi_meta <= spi_mosi;
      mosi_s    <= mosi_meta;
    end
  end

  state_t state_q, state_d;
  logic [4:0]           bit_cnt;
  logic [6:0]           sr_q;
  logic [ADDR_BITS-1:0] addr_q;
  logic                 is_read_q;
  logic [7:0]           tx_sr;
  logic                 fetch_q;
  logic                 miso_q;

  logic [7:0]           mem [DEPTH];
  logic [7:0]           rd_q;

  logic [7:0]           rx_byte;
  logic [ADDR_BITS-1:0] addr_shift;
  logic [ADDR_BITS-1:0] addr_inc;
  logic                 byte_done;
  logic                 opcode_ok;

  assign rx_byte    = {sr_q, mosi_s};
  assign addr_shift = {addr_q[ADDR_BITS-2:0], mosi_s};
  assign addr_inc   = addr_q + ADDR_BITS'(1);   // wraps DEPTH-1 -> 0
  assign byte_done  = (bit_cnt == 5'd7);
  assign opcode_ok  = (rx_byte == CMD_READ) || (rx_byte == CMD_WRITE);

  // ---- FSM: state register ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // ---- FSM: next state ----
  always_comb begin
    state_d = state_q;
    if (cs_rise) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        // Mode 0 idles SCLK low, so a select only counts while SCLK is low.
        ST_IDLE: if (cs_fall && !sclk_sync) state_d = ST_CMD;
        ST_CMD:  if (sclk_rise && byte_done) state_d = opcode_ok ? ST_ADDR : ST_IGNORE;
        ST_ADDR: if (sclk_rise && bit_cnt == LAST_ADDR_BIT)
                   state_d = is_read_q ? ST_READ : ST_WRITE;
        default: state_d = state_q;
      endcase
    end
  end

  // ---- FSM: output strobes ----
  logic                 spi_we;
  logic                 fetch;
  logic [ADDR_BITS-1:0] fetch_addr;
  logic                 cmd_err_d;

  always_comb begin
    spi_we     = 1'b0;
    fetch      = 1'b0;
    fetch_addr = addr_inc;
    cmd_err_d  = 1'b0;
    if (!cs_rise) begin
      case (state_q)
        ST_CMD:   cmd_err_d = sclk_rise && byte_done && !opcode_ok;
        ST_ADDR:  if (sclk_rise && bit_cnt == LAST_ADDR_BIT && is_read_q) begin
                    fetch      = 1'b1;
                    fetch_addr = addr_shift;
                  end
        ST_READ:  fetch  = sclk_fall && byte_done;   // prefetch the next byte
        ST_WRITE: spi_we = sclk_rise && byte_done;
        default:  ;
      endcase
    end
  end

  // ---- Datapath ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_cnt   <= '0;
      sr_q      <= '0;
      addr_q    <= '0;
      is_read_q <= 1'b0;
      tx_sr     <= '0;
      fetch_q   <= 1'b0;
      miso_q    <= 1'b0;
      cmd_err   <= 1'b0;
    end else begin
      fetch_q <= fetch;
      cmd_err <= cmd_err_d;
      if (cs_rise || state_q == ST_IDLE) begin
        // Dropping CS discards any partial byte: the counter restarts and no write fires.
        bit_cnt <= '0;
        miso_q  <= 1'b0;
      end else begin
        case (state_q)
          ST_CMD: if (sclk_rise) begin
            sr_q <= rx_byte[6:0];
            if (byte_done) begin
              bit_cnt   <= '0;
              is_read_q <= (rx_byte == CMD_READ);
            end else begin
              bit_cnt <= bit_cnt + 5'd1;
            end
          end
          ST_ADDR: if (sclk_rise) begin
            addr_q  <= addr_shift;   // upper address bits fall off the top
            bit_cnt <= (bit_cnt == LAST_ADDR_BIT) ? 5'd0 : bit_cnt + 5'd1;
          end
          ST_READ: begin
            // The reload lands well before the next SCLK fall given the clk ratio.
            if (fetch_q) begin
              tx_sr <= rd_q;
            end else if (sclk_fall) begin
              miso_q <= tx_sr[7];
              tx_sr  <= {tx_sr[6:0], 1'b0};
              if (byte_done) begin
                bit_cnt <= '0;
                addr_q  <= addr_inc;
              end else begin
                bit_cnt <= bit_cnt + 5'd1;
              end
            end
          end
          ST_WRITE: if (sclk_rise) begin
            sr_q <= rx_byte[6:0];
            if (byte_done) begin
              bit_cnt <= '0;
              addr_q  <= addr_inc;
            end else begin
              bit_cnt <= bit_cnt + 5'd1;
            end
          end
          default: miso_q <= 1'b0;
        endcase
      end
    end
  end

  // ---- Byte array: SPI write wins a same-cycle collision with the backdoor ----
  always_ff @(posedge clk) begin
    if (spi_we)     mem[addr_q]  <= rx_byte;
    else if (bd_we) mem[bd_addr] <= bd_wdata;
    rd_q <= mem[fetch_addr];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) bd_rdata <= '0;
    else       bd_rdata <= mem[bd_addr];
  end

  assign spi_miso = miso_q;
  assign busy     = ~cs_sync;

endmodule

// File: tb/tb_spi_ram_responder.sv
// Directed bench for spi_ram_responder: SPI mode-0 master model plus backdoor access.
// Latency: n/a. Backpressure: n/a.
// Every check goes through chk(); the last line printed is the summary.
module tb_spi_ram_responder;

  localparam int AW   = 10;
  localparam int HALF = 8;   // SCLK half period in clk cycles

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          spi_clk = 1'b0;
  logic          spi_cs_n = 1'b1;
  logic          spi_mosi = 1'b0;
  logic          spi_miso;
  logic          busy;
  logic          cmd_err;
  logic          bd_we = 1'b0;
  logic [AW-1:0] bd_addr = '0;
  logic [7:0]    bd_wdata = '0;
  logic [7:0]    bd_rdata;

  int n_vec = 0;
  int n_err = 0;
  int err_pulses = 0;

  spi_ram_responder #(.ADDR_BITS(AW)) dut (
    .clk(clk), .reset(reset),
    .spi_clk(spi_clk), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
    .busy(busy), .cmd_err(cmd_err),
    .bd_we(bd_we), .bd_addr(bd_addr), .bd_wdata(bd_wdata), .bd_rdata(bd_rdata)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (cmd_err) err_pulses++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bd_write(input logic [AW-1:0] a, input logic [7:0] d);
    @(negedge clk);
    bd_we = 1'b1; bd_addr = a; bd_wdata = d;
    @(negedge clk);
    bd_we = 1'b0;
  endtask

  task automatic bd_read(input logic [AW-1:0] a, output logic [7:0] d);
    @(negedge clk);
    bd_addr = a;
    @(negedge clk);
    d = bd_rdata;
  endtask

  // Mode 0: MOSI set up while SCLK low, MISO sampled just before the rising edge.
  task automatic spi_bit(input logic b, output logic r);
    spi_mosi = b;
    wait_clk(HALF);
    r = spi_miso;
    spi_clk = 1'b1;
    wait_clk(HALF);
    spi_clk = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
    for (int i = 7; i >= 0; i--) spi_bit(tx[i], rx[i]);
  endtask

  task automatic spi_start(input logic [7:0] op, input logic [23:0] a);
    logic [7:0] rx;
    spi_cs_n = 1'b0;
    wait_clk(HALF);
    spi_byte(op, rx);
    spi_byte(a[23:16], rx);
    spi_byte(a[15:8], rx);
    spi_byte(a[7:0], rx);
  endtask

  task automatic spi_stop();
    wait_clk(HALF);
    spi_cs_n = 1'b1;
    wait_clk(HALF);
  endtask

  logic [7:0] rx;
  logic [7:0] d;
  logic       b;
  int         base;

  initial begin
    // Reset state
    wait_clk(4);
    chk("rst_miso", spi_miso, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_cmd_err", cmd_err, 1'b0);
    chk("rst_bd_rdata", bd_rdata, 8'h00);
    reset = 1'b0;
    wait_clk(4);

    // SPI write 02 000010 A5 3C
    spi_start(8'h02, 24'h000010);
    chk("wr_busy", busy, 1'b1);
    spi_byte(8'hA5, rx);
    spi_byte(8'h3C, rx);
    spi_stop();
    chk("wr_busy_off", busy, 1'b0);
    bd_read(10'h010, d); chk("wr_10", d, 8'hA5);
    bd_read(10'h011, d); chk("wr_11", d, 8'h3C);
    chk("wr_no_err", err_pulses, 0);

    // Backdoor preload, SPI read of three sequential bytes
    bd_write(10'h020, 8'h11);
    bd_write(10'h021, 8'h22);
    bd_write(10'h022, 8'h33);
    spi_start(8'h03, 24'h000020);
    spi_byte(8'h00, rx); chk("rd_20", rx, 8'h11);
    spi_byte(8'h00, rx); chk("rd_21", rx, 8'h22);
    spi_byte(8'h00, rx); chk("rd_22", rx, 8'h33);
    spi_stop();

    // Address wrap on read and on write
    bd_write(10'h3FF, 8'h77);
    bd_write(10'h000, 8'h88);
    spi_start(8'h03, 24'h0003FF);
    spi_byte(8'h00, rx); chk("rdwrap_3ff", rx, 8'h77);
    spi_byte(8'h00, rx); chk("rdwrap_000", rx, 8'h88);
    spi_stop();
    spi_start(8'h02, 24'h0003FF);
    spi_byte(8'hC1, rx);
    spi_byte(8'hD2, rx);
    spi_stop();
    bd_read(10'h3FF, d); chk("wrwrap_3ff", d, 8'hC1);
    bd_read(10'h000, d); chk("wrwrap_000", d, 8'hD2);

    // Unknown opcode: one cmd_err pulse, MISO quiet, array untouched
    base = err_pulses;
    spi_cs_n = 1'b0;
    wait_clk(HALF);
    spi_byte(8'h9F, rx);
    d = 8'h00;
    spi_byte(8'h00, rx); d = d | rx;
    spi_byte(8'h00, rx); d = d | rx;
    spi_byte(8'h00, rx); d = d | rx;
    spi_byte(8'h5A, rx); d = d | rx;
    spi_stop();
    chk("bad_miso", d, 8'h00);
    chk("bad_err_cnt", err_pulses - base, 1);
    bd_read(10'h000, d); chk("bad_mem0", d, 8'hD2);

    // Abort after 5 bits of a write data byte
    bd_write(10'h040, 8'hE7);
    spi_start(8'h02, 24'h000040);
    for (int i = 0; i < 5; i++) spi_bit(1'b1, b);
    spi_stop();
    bd_read(10'h040, d); chk("abort_mem40", d, 8'hE7);
    spi_start(8'h03, 24'h000040);
    spi_byte(8'h00, rx); chk("abort_rd40", rx, 8'hE7);
    spi_stop();

    // Reset in the middle of a read after 12 data bits
    spi_start(8'h03, 24'h000010);
    spi_byte(8'h00, rx); chk("mid_rd10", rx, 8'hA5);
    for (int i = 0; i < 4; i++) spi_bit(1'b0, b);
    wait_clk(6);
    chk("mid_miso_pre", spi_miso, 1'b1);   // bit 3 of 3C is on the wire
    @(negedge clk);
    reset = 1'b1;
    wait_clk(2);
    chk("mid_rst_miso", spi_miso, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    spi_cs_n = 1'b1;
    wait_clk(2);
    reset = 1'b0;
    wait_clk(HALF);
    spi_start(8'h03, 24'h000010);
    spi_byte(8'h00, rx); chk("post_rst_rd10", rx, 8'hA5);
    spi_stop();
    chk("post_rst_idle_miso", spi_miso, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Hard stop in case the bench itself stalls.
  initial begin
    #2000000;
    $display("FAIL timeout: got no finish, expected finish before time limit");
    $fatal(1);
  end

endmodule
